// File: rtl/ro_meas_ctrl_if.sv
// ----------------------------------------------------------------------------
// ro_meas_ctrl_if
// Host-side handshake bundle for the ring-oscillator measurement sequencer.
//   master : host / scan controller (drives START, ABORT, SEL, WINDOW)
//   slave  : ro_meas_ctrl          (drives BUSY, DONE, COUNT, OVF, ERR)
// Signals:
//   START   request, sampled only while the sequencer is idle
//   ABORT   cancels an active measurement
//   SEL     oscillator index, latched on START
//   WINDOW  count window in CLK cycles, latched on START
//   BUSY    high while settling or measuring
//   DONE    one-cycle completion pulse
//   COUNT   last measured edge count
//   OVF     edge counter saturated during the last measurement
//   ERR     last request selected a non-existent oscillator
// ----------------------------------------------------------------------------
interface ro_meas_ctrl_if #(
  parameter int SEL_W = 2,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) ();
  logic             START;
  logic             ABORT;
  logic [SEL_W-1:0] SEL;
  logic [WIN_W-1:0] WINDOW;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] COUNT;
  logic             OVF;
  logic             ERR;

  modport master (
    output START, ABORT, SEL, WINDOW,
    input  BUSY, DONE, COUNT, OVF, ERR
  );

  modport slave (
    input  START, ABORT, SEL, WINDOW,
    output BUSY, DONE, COUNT, OVF, ERR
  );
endinterface

// File: rtl/ro_meas_ctrl.sv
// ----------------------------------------------------------------------------
// ro_meas_ctrl
// Measurement sequencer for on-die ring-oscillator delay monitors. Enables one
// of NUM_RO oscillators, lets it run for SETTLE cycles, then counts its rising
// edges over WINDOW CLK cycles and reports the count to the host.
// Ports:
//   CLK      system clock, all state on its rising edge
//   RESET_B  asynchronous active-low reset
//   RO_IN    divided oscillator outputs, asynchronous to CLK
//   RO_EN    registered one-hot oscillator enables
//   bus      host handshake (ro_meas_ctrl_if.slave)
// ----------------------------------------------------------------------------
module ro_meas_ctrl #(
  parameter int NUM_RO = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int SETTLE = 8
) (
  input  logic              CLK,
  input  logic              RESET_B,
  input  logic [NUM_RO-1:0] RO_IN,
  output logic [NUM_RO-1:0] RO_EN,
  ro_meas_ctrl_if.slave     bus
);

  // One timer serves both the settle phase and the count window.
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t            state_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic [WIN_W-1:0]  win_reg;
  logic [TMR_W-1:0]  tmr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              ovf_reg;
  logic              sync1_reg;
  logic              sync2_reg;
  logic              prev_reg;

  logic [NUM_RO-1:0] req_hit;   // decode of the incoming SEL
  logic [NUM_RO-1:0] lat_hit;   // decode of the latched SEL
  logic [NUM_RO-1:0] ro_gated;
  logic              sel_ok;
  logic              ro_mux;
  logic              rise;
  logic              cnt_sat;
  logic [CNT_W-1:0]  cnt_next;
  logic              ovf_next;

  // Decoding by comparison keeps out-of-range SEL values harmless: they
  // simply match no oscillator, which is also how they are detected.
  for (genvar gi = 0; gi < NUM_RO; gi++) begin : g_dec
    assign req_hit[gi]  = (bus.SEL == SEL_W'(gi));
    assign lat_hit[gi]  = (sel_reg == SEL_W'(gi));
    assign ro_gated[gi] = RO_IN[gi] & lat_hit[gi];
  end

  assign sel_ok = |req_hit;
  assign ro_mux = |ro_gated;

  // Rising edge of the synchronised oscillator; prev_reg is the third flop.
  assign rise     = sync2_reg & ~prev_reg;
  assign cnt_sat  = &cnt_reg;
  assign cnt_next = (rise && !cnt_sat) ? cnt_reg + CNT_W'(1) : cnt_reg;
  assign ovf_next = ovf_reg | (rise & cnt_sat);

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_reg <= S_IDLE;
      sel_reg   <= '0;
      win_reg   <= '0;
      tmr_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
      RO_EN     <= '0;
      bus.BUSY  <= 1'b0;
      bus.DONE  <= 1'b0;
      bus.COUNT <= '0;
      bus.OVF   <= 1'b0;
      bus.ERR   <= 1'b0;
    end else begin
      bus.DONE  <= 1'b0;
      // Synchroniser runs continuously; it is cleared on settle entry and has
      // SETTLE cycles to fill, so the first measure cycle sees no false edge.
      sync1_reg <= ro_mux;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;

      case (state_reg)
        S_IDLE: begin
          if (bus.START) begin
            sel_reg <= bus.SEL;
            win_reg <= bus.WINDOW;
            if (!sel_ok) begin
              state_reg <= S_DONE;
              bus.DONE  <= 1'b1;
              bus.COUNT <= '0;
              bus.OVF   <= 1'b0;
              bus.ERR   <= 1'b1;
            end else begin
              state_reg <= S_SETTLE;
              tmr_reg   <= TMR_W'(SETTLE - 1);
              cnt_reg   <= '0;
              ovf_reg   <= 1'b0;
              sync1_reg <= 1'b0;
              sync2_reg <= 1'b0;
              prev_reg  <= 1'b0;
              RO_EN     <= req_hit;
              bus.BUSY  <= 1'b1;
            end
          end
        end

        S_SETTLE: begin
          if (bus.ABORT) begin
            state_reg <= S_IDLE;
            RO_EN     <= '0;
            bus.BUSY  <= 1'b0;
          end else if (tmr_reg == '0) begin
            if (win_reg == '0) begin
              state_reg <= S_DONE;
              RO_EN     <= '0;
              bus.BUSY  <= 1'b0;
              bus.DONE  <= 1'b1;
              bus.COUNT <= '0;
              bus.OVF   <= 1'b0;
              bus.ERR   <= 1'b0;
            end else begin
              state_reg <= S_MEASURE;
              tmr_reg   <= TMR_W'(win_reg) - TMR_W'(1);
            end
          end else begin
            tmr_reg <= tmr_reg - TMR_W'(1);
          end
        end

        S_MEASURE: begin
          if (bus.ABORT) begin
            state_reg <= S_IDLE;
            RO_EN     <= '0;
            bus.BUSY  <= 1'b0;
          end else begin
            cnt_reg <= cnt_next;
            ovf_reg <= ovf_next;
            if (tmr_reg == '0) begin
              // Publish including any edge seen in the final window cycle.
              state_reg <= S_DONE;
              RO_EN     <= '0;
              bus.BUSY  <= 1'b0;
              bus.DONE  <= 1'b1;
              bus.COUNT <= cnt_next;
              bus.OVF   <= ovf_next;
              bus.ERR   <= 1'b0;
            end else begin
              tmr_reg <= tmr_reg - TMR_W'(1);
            end
          end
        end

        S_DONE: begin
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
          RO_EN     <= '0;
          bus.BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ro_meas_ctrl
// Directed bench for ro_meas_ctrl. dut_a (SEL_W=3, CNT_W=16) covers the normal,
// zero-window, abort, reset and bad-select cases; dut_b (CNT_W=4) covers
// counter saturation. Inputs change and outputs are sampled on the falling
// edge; cycle k is the interval after rising edge k-1, START taken at edge 0.
// ----------------------------------------------------------------------------
module tb_ro_meas_ctrl;

  logic       CLK = 1'b0;
  logic       RESET_B = 1'b0;
  logic [3:0] ro_in = '0;
  logic [3:0] ro_mask = 4'b0100;
  logic [3:0] ro_en_a;
  logic [3:0] ro_en_b;
  int         ro_period = 6;
  int         ro_tick = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 CLK = ~CLK;

  // Divided-oscillator model: square wave, half high / half low.
  always @(negedge CLK) begin
    ro_tick = (ro_tick + 1) % ro_period;
    ro_in   = (ro_tick < ro_period / 2) ? ro_mask : 4'b0000;
  end

  ro_meas_ctrl_if #(.SEL_W(3), .CNT_W(16), .WIN_W(16)) bus_a ();
  ro_meas_ctrl_if #(.SEL_W(2), .CNT_W(4),  .WIN_W(16)) bus_b ();

  ro_meas_ctrl #(.NUM_RO(4), .SEL_W(3), .CNT_W(16), .WIN_W(16), .SETTLE(8)) dut_a (
    .CLK     (CLK),
    .RESET_B (RESET_B),
    .RO_IN   (ro_in),
    .RO_EN   (ro_en_a),
    .bus     (bus_a)
  );

  ro_meas_ctrl #(.NUM_RO(4), .SEL_W(2), .CNT_W(4), .WIN_W(16), .SETTLE(8)) dut_b (
    .CLK     (CLK),
    .RESET_B (RESET_B),
    .RO_IN   (ro_in),
    .RO_EN   (ro_en_b),
    .bus     (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue a request on dut_a; returns at the falling edge of cycle 1 with
  // SEL/WINDOW scribbled to show they are ignored while busy.
  task automatic start_a(input logic [2:0] sel, input logic [15:0] win);
    bus_a.START  = 1'b1;
    bus_a.SEL    = sel;
    bus_a.WINDOW = win;
    @(negedge CLK);
    bus_a.START  = 1'b0;
    bus_a.SEL    = 3'd7;
    bus_a.WINDOW = 16'hFFFF;
  endtask

  // Full measurement on dut_a with a cycle-by-cycle check of enables/handshake.
  task automatic run_a(input logic [2:0] sel, input int win, input int exp_cnt);
    int         last;
    logic [3:0] oh;
    logic [5:0] expv;
    last = 1 + 8 + win;
    oh   = 4'b0001 << sel[1:0];
    start_a(sel, 16'(win));
    for (int c = 1; c <= last; c++) begin
      expv = (c < last) ? {oh, 1'b1, 1'b0} : {4'b0000, 1'b0, 1'b1};
      chk($sformatf("seq_w%0d_c%0d", win, c), 32'({ro_en_a, bus_a.BUSY, bus_a.DONE}), 32'(expv));
      if (c == last) begin
        chk("count", 32'(bus_a.COUNT), 32'(exp_cnt));
        chk("ovf", 32'(bus_a.OVF), 32'(0));
        chk("err", 32'(bus_a.ERR), 32'(0));
      end
      @(negedge CLK);
    end
    chk("done_one_cycle", 32'(bus_a.DONE), 32'(0));
    chk("count_held", 32'(bus_a.COUNT), 32'(exp_cnt));
    $display("txn sel=%0d win=%0d count=%0d ovf=%0b err=%0b", sel, win, bus_a.COUNT, bus_a.OVF, bus_a.ERR);
  endtask

  initial begin
    int dones;
    bus_a.START = 1'b0; bus_a.ABORT = 1'b0; bus_a.SEL = '0; bus_a.WINDOW = '0;
    bus_b.START = 1'b0; bus_b.ABORT = 1'b0; bus_b.SEL = '0; bus_b.WINDOW = '0;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_outputs", 32'({ro_en_a, bus_a.BUSY, bus_a.DONE, bus_a.OVF, bus_a.ERR}), 32'(0));
    chk("rst_count", 32'(bus_a.COUNT), 32'(0));
    RESET_B = 1'b1;
    @(negedge CLK);
    $display("txn reset released");

    // Zero window: DONE at cycle 1+SETTLE with COUNT=0
    run_a(3'd2, 0, 0);
    // Normal measurement: period 6, window 60 -> 10 edges
    run_a(3'd2, 60, 10);

    // Abort in the 20th measure cycle (cycle 28)
    start_a(3'd2, 16'd60);
    repeat (27) @(negedge CLK);
    chk("abort_busy_before", 32'(bus_a.BUSY), 32'(1));
    bus_a.ABORT = 1'b1;
    @(negedge CLK);
    bus_a.ABORT = 1'b0;
    chk("abort_busy_after", 32'(bus_a.BUSY), 32'(0));
    chk("abort_ro_en", 32'(ro_en_a), 32'(0));
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus_a.DONE) dones++;
      @(negedge CLK);
    end
    chk("abort_no_done", 32'(dones), 32'(0));
    chk("abort_count_kept", 32'(bus_a.COUNT), 32'(10));
    $display("txn abort count=%0d busy=%0b", bus_a.COUNT, bus_a.BUSY);

    // Asynchronous reset in the middle of a measurement
    start_a(3'd2, 16'd60);
    repeat (29) @(negedge CLK);
    chk("pre_rst_busy", 32'(bus_a.BUSY), 32'(1));
    #2 RESET_B = 1'b0;
    #1;
    chk("async_rst_outputs", 32'({ro_en_a, bus_a.BUSY, bus_a.DONE, bus_a.OVF, bus_a.ERR}), 32'(0));
    chk("async_rst_count", 32'(bus_a.COUNT), 32'(0));
    @(negedge CLK);
    RESET_B = 1'b1;
    @(negedge CLK);
    chk("post_rst_idle", 32'({ro_en_a, bus_a.BUSY}), 32'(0));
    $display("txn mid-measure reset");

    // Normal operation after reset, different oscillator
    ro_mask = 4'b0010;
    run_a(3'd1, 60, 10);

    // Bad select; START held through DONE_S must not be accepted
    bus_a.START = 1'b1; bus_a.SEL = 3'd5; bus_a.WINDOW = 16'd60;
    @(negedge CLK);
    chk("err_done", 32'(bus_a.DONE), 32'(1));
    chk("err_flag", 32'(bus_a.ERR), 32'(1));
    chk("err_count", 32'(bus_a.COUNT), 32'(0));
    chk("err_busy_en", 32'({ro_en_a, bus_a.BUSY}), 32'(0));
    @(negedge CLK);
    bus_a.START = 1'b0;
    chk("err_start_ignored_c2", 32'({ro_en_a, bus_a.BUSY, bus_a.DONE}), 32'(0));
    @(negedge CLK);
    chk("err_start_ignored_c3", 32'({ro_en_a, bus_a.BUSY, bus_a.DONE}), 32'(0));
    chk("err_held", 32'(bus_a.ERR), 32'(1));
    $display("txn sel=5 err=%0b count=%0d", bus_a.ERR, bus_a.COUNT);

    // Saturation on the 4-bit counter: period 4, window 200 -> 50 edges
    ro_period = 4;
    ro_mask   = 4'b0010;
    bus_b.START = 1'b1; bus_b.SEL = 2'd1; bus_b.WINDOW = 16'd200;
    @(negedge CLK);
    bus_b.START = 1'b0;
    for (int c = 1; c <= 209; c++) begin
      if (c == 208) chk("ovf_busy_c208", 32'({bus_b.BUSY, bus_b.DONE}), 32'(2));
      if (c == 209) begin
        chk("ovf_done_c209", 32'({bus_b.BUSY, bus_b.DONE}), 32'(1));
        chk("ovf_count", 32'(bus_b.COUNT), 32'(15));
        chk("ovf_flag", 32'(bus_b.OVF), 32'(1));
        chk("ovf_err", 32'(bus_b.ERR), 32'(0));
      end
      @(negedge CLK);
    end
    $display("txn sat win=200 count=%0d ovf=%0b", bus_b.COUNT, bus_b.OVF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ro_meas_ctrl.md
Name: ro_meas_ctrl

Overview:
- Measurement sequencer for on-die ring-oscillator (RO) delay monitors built from the hs inverter and nand2 cells. Each RO output is divided down before it reaches this block.
- Selects one of NUM_RO oscillators and enables it.
- Waits a settle period, then counts the oscillator's rising edges over a programmable window of CLK cycles.
- Returns the count to the host/scan controller through a START/BUSY/DONE handshake.

Parameters:
- NUM_RO, 4, number of oscillators sequenced.
- SEL_W, 2, width of SEL (must satisfy 2^SEL_W >= NUM_RO).
- CNT_W, 16, width of the edge counter and COUNT.
- WIN_W, 16, width of WINDOW.
- SETTLE, 8, CLK cycles the RO runs before counting starts (must be >= 3).

Ports:
- CLK  input  1  system clock; all state is on its rising edge.
- RESET_B  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only in IDLE.
- ABORT  input  1  cancels an active measurement.
- SEL  input  SEL_W  oscillator index; latched on START.
- WINDOW  input  WIN_W  count window in CLK cycles; latched on START.
- RO_IN  input  NUM_RO  divided RO outputs, asynchronous to CLK.
- RO_EN  output  NUM_RO  one-hot oscillator enables.
- BUSY  output  1  high in SETTLE and MEASURE.
- DONE  output  1  one-cycle completion pulse.
- COUNT  output  CNT_W  last measured edge count.
- OVF  output  1  counter saturated during the last measurement.
- ERR  output  1  last request had SEL >= NUM_RO.

Behaviour:
- Reset
  - RESET_B low forces, immediately and asynchronously: state IDLE, RO_EN=0, BUSY=0, DONE=0, COUNT=0, OVF=0, ERR=0, synchronizer flops=0, timers=0.
  - Reset release is synchronised externally.
- States: IDLE, SETTLE, MEASURE, DONE_S.
- IDLE
  - START=1 latches SEL and WINDOW.
  - If SEL >= NUM_RO: go to DONE_S with error result (COUNT=0, OVF=0, ERR=1).
  - Otherwise go to SETTLE, load the settle timer with SETTLE-1, clear the synchronizer and edge counter.
- SETTLE
  - RO_EN = one-hot(latched SEL); BUSY=1.
  - Lasts exactly SETTLE cycles, then MEASURE with the window timer loaded from WINDOW.
  - If WINDOW=0, go directly to DONE_S with COUNT=0.
- MEASURE
  - RO_EN held; BUSY=1; lasts exactly WINDOW cycles.
  - Each cycle where the synchronised RO rises (sync2=1, prev=0) increments the counter.
  - The counter saturates at 2^CNT_W-1 and sets the internal overflow flag.
  - Then go to DONE_S.
- Synchronizer
  - Selected RO_IN bit is muxed, then passes through 2 flops and an edge-detect flop, clocked by CLK.
  - Cleared on SETTLE entry.
  - Runs during SETTLE, so no spurious edge appears at MEASURE start.
  - RO_IN frequency is <= CLK/4 by system design.
- DONE_S
  - One cycle: DONE=1, BUSY=0, RO_EN=0.
  - COUNT, OVF and ERR are updated in this cycle and held until the next DONE_S.
  - Always returns to IDLE; START during DONE_S is ignored.
- ABORT
  - Has priority over all other transitions in SETTLE or MEASURE.
  - Next state is IDLE with RO_EN=0, no DONE pulse, and COUNT/OVF/ERR unchanged.
  - Ignored in IDLE and DONE_S.
- Latency
  - START accepted at edge 0 gives BUSY=1 from cycle 1.
  - DONE is high in cycle 1+SETTLE+WINDOW.
  - Error path: DONE is high in cycle 1.
- RO_EN is registered and glitch-free; at most one bit is ever high.
- SEL and WINDOW changes while BUSY have no effect.

Test Plan:
- Reset mid-MEASURE (RESET_B low for 1 cycle), RO running → RO_EN=0 asynchronously, all outputs 0, state IDLE, next START works normally.
- SEL=2, WINDOW=60, SETTLE=8, RO_IN[2] period 6 CLK → RO_EN=4'b0100 for cycles 1–68, DONE in cycle 69, COUNT=10, OVF=0, ERR=0.
- SEL=5 with NUM_RO=4 (SEL_W=3) → DONE in cycle 1, ERR=1, COUNT=0, RO_EN never set; START held high during DONE_S is not accepted.
- CNT_W=4, WINDOW=200, RO period 4 CLK → COUNT=15, OVF=1.
- WINDOW=0 → DONE at cycle 1+SETTLE, COUNT=0, OVF=0.
- ABORT in cycle 20 of MEASURE after a prior result COUNT=10 → BUSY drops next cycle, no DONE, COUNT stays 10.
